// File: rtl/hough_accumulator_scheduler.sv
// Frame sequencer for the Hough accumulator RAM: clear all bins, collect saturating
// votes through a read-modify-write engine, then stream every bin to the peak search.
module hough_accumulator_scheduler #(
    parameter int unsigned R_BINS   = 800,
    parameter int unsigned N_ANGLES = 45,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              scan_start,
    input  logic              scan_done,
    input  logic              vote_valid,
    input  logic [12:0]       vote_r,
    input  logic [7:0]        vote_angle,
    output logic              vote_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [CNT_W-1:0]  mem_wdata,
    input  logic [CNT_W-1:0]  mem_rdata,
    output logic              acc_valid,
    output logic [CNT_W-1:0]  acc_count,
    output logic [9:0]        acc_r,
    output logic [5:0]        acc_angle_idx,
    output logic              busy,
    output logic              done,
    output logic [15:0]       discard_count,
    output logic              overflow_err
);
    localparam int unsigned       DEPTH     = R_BINS * N_ANGLES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [9:0]        LAST_R    = 10'(R_BINS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_VOTE, S_DRAIN, S_SEARCH} state_t;
    typedef enum logic [1:0] {RMW_IDLE, RMW_READ, RMW_WAIT} rmw_t;

    state_t state;
    rmw_t   rmw;

    logic             search_run;
    logic [9:0]       r_cnt;
    logic [5:0]       a_cnt;
    logic             p1_valid;
    logic [9:0]       p1_r;
    logic [5:0]       p1_a;
    logic             p2_valid;
    logic [CNT_W-1:0] p2_cnt;
    logic [9:0]       p2_r;
    logic [5:0]       p2_a;

    // Vote decode: range filter, flat bin address and saturating increment
    logic [5:0]        angle_idx_c;
    logic              vote_ok_c;
    logic              handshake_c;
    logic [ADDR_W-1:0] vote_addr_c;
    logic [CNT_W-1:0]  sat_inc_c;

    assign angle_idx_c = vote_angle[7:2];
    assign vote_ok_c   = !vote_r[12] && (32'(vote_r[11:0]) < R_BINS) &&
                         (vote_angle[1:0] == 2'b00) && (32'(angle_idx_c) < N_ANGLES);
    assign vote_addr_c = ADDR_W'(32'(angle_idx_c) * R_BINS + 32'(vote_r[11:0]));
    assign handshake_c = vote_valid && vote_ready;
    assign sat_inc_c   = (&mem_rdata) ? mem_rdata : mem_rdata + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rmw           <= RMW_IDLE;
            search_run    <= 1'b0;
            r_cnt         <= '0;
            a_cnt         <= '0;
            p1_valid      <= 1'b0;
            p1_r          <= '0;
            p1_a          <= '0;
            p2_valid      <= 1'b0;
            p2_cnt        <= '0;
            p2_r          <= '0;
            p2_a          <= '0;
            scan_start    <= 1'b0;
            vote_ready    <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            acc_valid     <= 1'b0;
            acc_count     <= '0;
            acc_r         <= '0;
            acc_angle_idx <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            discard_count <= '0;
            overflow_err  <= 1'b0;
        end else begin
            scan_start <= 1'b0;
            done       <= 1'b0;
            mem_we     <= 1'b0;

            // Search read pipeline: address cycle, RAM data cycle, output register
            p1_valid      <= (state == S_SEARCH) && search_run;
            p1_r          <= r_cnt;
            p1_a          <= a_cnt;
            p2_valid      <= p1_valid;
            p2_cnt        <= mem_rdata;
            p2_r          <= p1_r;
            p2_a          <= p1_a;
            acc_valid     <= p2_valid;
            acc_count     <= p2_valid ? p2_cnt : '0;
            acc_r         <= p2_valid ? p2_r : '0;
            acc_angle_idx <= p2_valid ? p2_a : '0;

            if ((state == S_VOTE || state == S_DRAIN) && vote_valid && !vote_ready)
                overflow_err <= 1'b1;

            case (rmw)
                RMW_READ: rmw <= RMW_WAIT;
                RMW_WAIT: begin
                    rmw       <= RMW_IDLE;
                    mem_we    <= 1'b1;
                    mem_wdata <= sat_inc_c;
                    if (state == S_VOTE) vote_ready <= 1'b1;
                end
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_CLEAR;
                        busy          <= 1'b1;
                        mem_addr      <= '0;
                        mem_we        <= 1'b1;
                        mem_wdata     <= '0;
                        discard_count <= '0;
                        overflow_err  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (mem_addr == LAST_ADDR) begin
                        state      <= S_VOTE;
                        scan_start <= 1'b1;
                        vote_ready <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_we   <= 1'b1;
                    end
                end
                S_VOTE: begin
                    if (handshake_c) begin
                        if (vote_ok_c) begin
                            mem_addr   <= vote_addr_c;
                            rmw        <= RMW_READ;
                            vote_ready <= 1'b0;
                        end else if (discard_count != 16'hFFFF) begin
                            discard_count <= discard_count + 16'd1;
                        end
                    end
                    // An accepted vote in the same cycle still finishes in DRAIN
                    if (scan_done) begin
                        state      <= S_DRAIN;
                        vote_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (rmw == RMW_IDLE) begin
                        state      <= S_SEARCH;
                        mem_addr   <= '0;
                        r_cnt      <= '0;
                        a_cnt      <= '0;
                        search_run <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (search_run) begin
                        if (mem_addr == LAST_ADDR) begin
                            search_run <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            if (r_cnt == LAST_R) begin
                                r_cnt <= '0;
                                a_cnt <= a_cnt + 6'd1;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                    end else if (acc_valid && !p1_valid && !p2_valid) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hough_accumulator_scheduler.sv
// Directed bench for hough_accumulator_scheduler on an 8x3 accumulator with 2-bit counts.
module tb_hough_accumulator_scheduler;
    localparam int R_BINS   = 8;
    localparam int N_ANGLES = 3;
    localparam int ADDR_W   = 16;
    localparam int CNT_W    = 2;
    localparam int DEPTH    = R_BINS * N_ANGLES;
    localparam int CNT_MAX  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              scan_done = 1'b0;
    logic              vote_valid = 1'b0;
    logic [12:0]       vote_r = '0;
    logic [7:0]        vote_angle = '0;
    logic              scan_start;
    logic              vote_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [CNT_W-1:0]  mem_wdata;
    logic [CNT_W-1:0]  mem_rdata = '0;
    logic              acc_valid;
    logic [CNT_W-1:0]  acc_count;
    logic [9:0]        acc_r;
    logic [5:0]        acc_angle_idx;
    logic              busy;
    logic              done;
    logic [15:0]       discard_count;
    logic              overflow_err;

    hough_accumulator_scheduler #(
        .R_BINS(R_BINS), .N_ANGLES(N_ANGLES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_start(scan_start),
        .scan_done(scan_done), .vote_valid(vote_valid), .vote_r(vote_r),
        .vote_angle(vote_angle), .vote_ready(vote_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .acc_valid(acc_valid), .acc_count(acc_count), .acc_r(acc_r),
        .acc_angle_idx(acc_angle_idx), .busy(busy), .done(done),
        .discard_count(discard_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write
    logic [CNT_W-1:0] ram [0:31];
    int wr_total = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[4:0]] <= mem_wdata;
            wr_total = wr_total + 1;
        end
        mem_rdata <= ram[mem_addr[4:0]];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl"}, 64'({scan_start, vote_ready, mem_we, acc_valid, busy, done,
                                   overflow_err, discard_count}), 64'd0);
        check({name, "_data"}, 64'({mem_addr, mem_wdata, acc_count, acc_r, acc_angle_idx}), 64'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (vote_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (vote_ready !== 1'b1) check("ready_timeout", 64'(vote_ready), 64'd1);
    endtask

    // Called at a negedge; leaves off at the negedge after the DEPTH-th clear write
    task automatic run_clear(input bool_poke_start);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            check("clear_write", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 16'(k), 2'b00}));
            start = (bool_poke_start && k == 10);
            @(negedge clk);
        end
        start = 1'b0;
        check("scan_start", 64'({scan_start, vote_ready, mem_we, busy}), 64'b1101);
    endtask

    // Waits for the stream then checks all DEPTH beats and the done pulse
    task automatic run_search(input int exp_cnt [DEPTH]);
        int n = 0;
        while (acc_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("search_start", 64'(acc_valid), 64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            check("beat", 64'({acc_valid, acc_count, acc_r, acc_angle_idx, done}),
                  64'({1'b1, 2'(exp_cnt[k]), 10'(k % R_BINS), 6'(k / R_BINS), 1'b0}));
            @(negedge clk);
        end
        check("done_pulse", 64'({done, busy, acc_valid}), 64'b100);
        @(negedge clk);
        check("done_clear", 64'({done, busy}), 64'b00);
    endtask

    typedef struct {
        logic [12:0] r;
        logic [7:0]  ang;
        bit          discard;
        int          addr;
    } vote_t;

    vote_t vt [12];
    int    exp_cnt [DEPTH];
    int    zero_cnt [DEPTH];
    int    wr0;

    initial begin
        vt[0]  = '{13'd5,    8'd4,  1'b0, 13};
        vt[1]  = '{13'd5,    8'd4,  1'b0, 13};
        vt[2]  = '{13'd5,    8'd4,  1'b0, 13};
        vt[3]  = '{13'h1FFF, 8'd0,  1'b1, 0};
        vt[4]  = '{13'd8,    8'd0,  1'b1, 0};
        vt[5]  = '{13'd0,    8'd6,  1'b1, 0};
        vt[6]  = '{13'd0,    8'd12, 1'b1, 0};
        for (int i = 7; i < 12; i++) vt[i] = '{13'd7, 8'd8, 1'b0, 23};
        for (int k = 0; k < DEPTH; k++) begin
            exp_cnt[k]  = 0;
            zero_cnt[k] = 0;
        end

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Pass 1: clear, table votes, coincident scan_done, overflow in DRAIN, search
        run_clear(1'b0);
        wr0 = wr_total;
        for (int i = 0; i < 12; i++) begin
            vote_r     = vt[i].r;
            vote_angle = vt[i].ang;
            vote_valid = 1'b1;
            wait_ready();
            @(negedge clk);
            vote_valid = 1'b0;
            if (vt[i].discard) begin
                check("discard_ready", 64'({vote_ready, mem_we}), 64'b10);
            end else begin
                check("rmw_read", 64'({vote_ready, mem_we, mem_addr}), 64'({2'b00, 16'(vt[i].addr)}));
                @(negedge clk);
                check("rmw_wait", 64'({vote_ready, mem_we}), 64'b00);
                @(negedge clk);
                if (exp_cnt[vt[i].addr] < CNT_MAX) exp_cnt[vt[i].addr]++;
                check("rmw_write", 64'({vote_ready, mem_we, mem_wdata}),
                      64'({2'b11, 2'(exp_cnt[vt[i].addr])}));
            end
        end
        check("discard_count", 64'(discard_count), 64'd4);
        check("ovf_clean", 64'(overflow_err), 64'd0);

        vote_r     = 13'd0;
        vote_angle = 8'd0;
        vote_valid = 1'b1;
        scan_done  = 1'b1;
        wait_ready();
        @(negedge clk);
        scan_done = 1'b0;
        check("last_read", 64'({vote_ready, mem_we, mem_addr}), 64'd0);
        @(negedge clk);
        vote_valid = 1'b0;
        check("ovf_set", 64'(overflow_err), 64'd1);
        @(negedge clk);
        exp_cnt[0] = 1;
        check("last_write", 64'({mem_we, mem_wdata}), 64'b101);
        run_search(exp_cnt);
        check("vote_writes", 64'(wr_total - wr0), 64'd9);
        check("ovf_sticky", 64'({overflow_err, discard_count}), 64'({1'b1, 16'd4}));

        // Pass 2: start clears status; stray scan_done ignored; reset mid-CLEAR
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clears", 64'({overflow_err, discard_count, busy}), 64'({1'b0, 16'd0, 1'b1}));
        repeat (3) @(negedge clk);
        scan_done = 1'b1;
        @(negedge clk);
        scan_done = 1'b0;
        check("clear_ignores_done", 64'({mem_we, mem_addr}), 64'({1'b1, 16'd4}));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Pass 3: full clean pass with a start pulse ignored during CLEAR
        run_clear(1'b1);
        scan_done = 1'b1;
        @(negedge clk);
        scan_done = 1'b0;
        run_search(zero_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

endmodule
